// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, PC step and FSM encoding for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

    localparam int unsigned DEF_CPU_WIDTH  = 32;
    localparam int unsigned DEF_INST_WIDTH = 32;
    localparam int unsigned DEF_IBUF_DEPTH = 2;
    localparam int unsigned PC_INC         = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_sync_fifo.sv
// Small synchronous FIFO with flush; head entry is read straight from registered storage.
module if_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign cnt       = cnt_q;

    // Flush only rewinds pointers; stale storage is never visible because cnt is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: credit-limited in-order imem requests, response buffering,
// decode handshake, and redirect flush with stale-response dropping.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned CPU_WIDTH  = DEF_CPU_WIDTH,
    parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
    parameter int unsigned IBUF_DEPTH = DEF_IBUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CPU_WIDTH-1:0]  curr_pc,
    output logic                  next_en,
    output logic [CPU_WIDTH-1:0]  next_pc,
    input  logic                  redirect_vld,
    input  logic [CPU_WIDTH-1:0]  redirect_pc,
    output logic                  imem_req_vld,
    input  logic                  imem_req_rdy,
    output logic [CPU_WIDTH-1:0]  imem_req_addr,
    input  logic                  imem_rsp_vld,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  id_vld,
    input  logic                  id_rdy,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [CPU_WIDTH-1:0]  id_pc
);

    localparam int unsigned CNT_W = $clog2(IBUF_DEPTH) + 1;
    localparam int unsigned INF_W = CNT_W + 1;
    localparam int unsigned ENT_W = CPU_WIDTH + INST_WIDTH;

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] pcq_cnt, ibuf_cnt;
    logic             pcq_empty, pcq_full, ibuf_empty, ibuf_full;
    logic [CPU_WIDTH-1:0] pcq_head;
    logic [ENT_W-1:0] ibuf_head, hold_q, id_ent;
    logic [INF_W-1:0] inflight;
    logic             credit_ok, redir, req_hs, rsp_take, id_hs;

    // pc queue occupancy doubles as the outstanding-request count.
    assign inflight      = INF_W'(pcq_cnt) + INF_W'(ibuf_cnt);
    assign credit_ok     = (inflight < INF_W'(IBUF_DEPTH)) && !pcq_full && !ibuf_full;
    assign redir         = redirect_vld && (state_q != ST_BOOT);
    assign imem_req_vld  = (state_q == ST_RUN) && !redirect_vld && credit_ok;
    assign imem_req_addr = curr_pc;
    assign req_hs        = imem_req_vld && imem_req_rdy;
    assign rsp_take      = (state_q == ST_RUN) && !redirect_vld && imem_rsp_vld && !pcq_empty;
    assign id_hs         = id_vld && id_rdy;

    assign id_vld  = !ibuf_empty;
    assign id_ent  = ibuf_empty ? hold_q : ibuf_head;
    assign id_pc   = id_ent[ENT_W-1:INST_WIDTH];
    assign id_inst = id_ent[INST_WIDTH-1:0];

    if_sync_fifo #(.WIDTH(CPU_WIDTH), .DEPTH(IBUF_DEPTH)) u_pc_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_hs),
        .push_data (curr_pc),
        .pop       (rsp_take),
        .flush     (redir),
        .head_data (pcq_head),
        .cnt       (pcq_cnt),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    if_sync_fifo #(.WIDTH(ENT_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_take),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (id_hs),
        .flush     (redir),
        .head_data (ibuf_head),
        .cnt       (ibuf_cnt),
        .empty     (ibuf_empty),
        .full      (ibuf_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            drop_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (!ibuf_empty) begin
                hold_q <= ibuf_head;
            end
        end
    end

    // Next state, drop counter and PC-register update.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        next_en = 1'b0;
        next_pc = curr_pc;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect_vld) begin
                    drop_d  = pcq_cnt - CNT_W'(imem_rsp_vld && !pcq_empty);
                    state_d = (drop_d != '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                drop_d = drop_q - CNT_W'(imem_rsp_vld && drop_q != '0);
                if (drop_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (!rst_n) begin
            next_pc = '0;
        end else if (redir) begin
            next_en = 1'b1;
            next_pc = redirect_pc;
        end else if (req_hs) begin
            next_en = 1'b1;
            next_pc = curr_pc + CPU_WIDTH'(PC_INC);
        end
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller that sits on the consumer side of the PC register. It reads curr_pc and returns next_en/next_pc to the register. It also issues in-order requests to instruction memory and buffers the returned instructions. Buffered instructions are handed to decode over a valid/ready handshake. Branch/jump redirects flush the fetch path and discard in-flight stale responses.

Parameters:
CPU_WIDTH, 32, PC/address width
INST_WIDTH, 32, instruction word width
IBUF_DEPTH, 2, instruction buffer entries; also the maximum outstanding requests plus buffered entries (credit limit); power of 2, >=2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
curr_pc  in  CPU_WIDTH  current PC from PC register
next_en  out  1  PC register update enable
next_pc  out  CPU_WIDTH  PC register next value
redirect_vld  in  1  branch/jump taken from execute
redirect_pc  in  CPU_WIDTH  redirect target
imem_req_vld  out  1  fetch request valid
imem_req_rdy  in  1  imem accepts request
imem_req_addr  out  CPU_WIDTH  fetch address (= curr_pc)
imem_rsp_vld  in  1  response valid; in order, one per accepted request, any latency >=1
imem_rsp_data  in  INST_WIDTH  fetched instruction
id_vld  out  1  instruction available to decode
id_rdy  in  1  decode accepts
id_inst  out  INST_WIDTH  instruction to decode
id_pc  out  CPU_WIDTH  PC of id_inst

Behaviour:
- Reset (rst_n low, async): FSM=BOOT; all counters, pointers and buffers cleared.
- Output values in reset: next_en=0, next_pc=0, imem_req_vld=0, id_vld=0, id_inst=0, id_pc=0.
- FSM states:
  - BOOT: one cycle after reset release; no request; redirect ignored. Goes to RUN.
  - RUN: normal fetch.
  - DRAIN: drop_cnt>0; no new requests. Goes to RUN on the cycle drop_cnt reaches 0.
- Issue condition: state==RUN && !redirect_vld && (outstd_cnt + ibuf_cnt) < IBUF_DEPTH.
  - When the condition holds: imem_req_vld=1, imem_req_addr=curr_pc. All request outputs are combinational.
  - Once imem_req_vld=1 it holds with a stable address until imem_req_rdy, unless a redirect arrives.
- Request handshake (vld&&rdy): next_en=1, next_pc=curr_pc+4, truncated to CPU_WIDTH (wraps at 2^CPU_WIDTH). Push curr_pc into the pc queue; outstd_cnt+1.
- Response in RUN: pop the pc queue and push {pc, imem_rsp_data} into ibuf the same cycle; outstd_cnt-1. The credit rule guarantees ibuf never overflows.
- Response with outstd_cnt==0: protocol violation; ignored, no state change.
- Decode side: id_vld = ibuf non-empty. id_inst/id_pc come from the ibuf head (registered storage). Pop on id_vld&&id_rdy. When empty, id_inst/id_pc hold their last values.
- A simultaneous ibuf push and pop is allowed; occupancy is unchanged.
- Redirect (redirect_vld in RUN or DRAIN):
  - Combinational next_en=1, next_pc=redirect_pc. No request is issued that cycle. Redirect has priority over request handshake.
  - ibuf and pc queue flush next edge. A same-cycle id handshake counts as consumed; a same-cycle response is dropped.
  - drop_cnt <= outstd_cnt minus (1 if a response arrives that cycle). outstd_cnt <= 0. Go to DRAIN if the new drop_cnt>0, else RUN.
- DRAIN: each imem_rsp_vld decrements drop_cnt; the data is discarded. A redirect in DRAIN updates the PC only; drop_cnt is unchanged unless a response arrives that cycle.
- next_en=0 and next_pc=curr_pc whenever neither a redirect nor a request handshake occurs.
- Counter widths: clog2(IBUF_DEPTH)+1 bits.

Decomposition:
- Shared package/defines: CPU_WIDTH, INST_WIDTH, PC increment constant (4), FSM state encodings (BOOT/RUN/DRAIN).
- One natural sub-module: if_sync_fifo (parameterised width/depth, push/pop/flush, cnt/empty/full). Instantiated twice: pc queue (CPU_WIDTH) and ibuf (CPU_WIDTH+INST_WIDTH).

Test Plan:
1. Reset then curr_pc=0, imem_req_rdy=1, 1-cycle response, id_rdy=1 -> BOOT cycle has no request. Requests then go to 0x0, 0x4, 0x8 with next_pc=0x4, 0x8, 0xC. id_pc sequence is 0x0, 0x4, 0x8 with matching id_inst.
2. id_rdy=0, response latency 1 -> exactly IBUF_DEPTH (2) requests issued, then imem_req_vld=0. On id_rdy=1, one pop frees a credit and a new request issues the next cycle.
3. imem_req_rdy=0 for 3 cycles -> imem_req_vld stays 1, addr stable, next_en=0; next_en pulses on the cycle rdy=1.
4. Two requests outstanding (latency 4), redirect_vld with redirect_pc=0x100 -> next_en=1, next_pc=0x100; FSM=DRAIN with drop_cnt=2. Both responses never reach id_vld; the first new request goes to 0x100 after the drain.
5. curr_pc=0xFFFF_FFFC, handshake -> next_pc=0x0000_0000 (wrap).
6. rst_n asserted mid-fetch with 2 outstanding and a full ibuf -> all outputs 0 immediately; after release, the BOOT cycle precedes any new request.
